sys_input_skew: RTL and testbench

//  Systolic input setup stage between global buffers A/B and the 8x8 PE array.
//  - Takes one LANES-wide word per cycle from a buffer read port.
//  - Aligns the controller's ensys/bubble strobes to the buffer read latency.
//  - Zeroes bubble/idle slots.
//  - Delays lane k by k cycles, producing the diagonal wavefront the array needs.
//  - One instance per operand: A rows, B columns.

---
 rtl/sys_input_skew_if.sv | 33 +++
 rtl/sys_input_skew.sv | 134 +++++++++++++
 tb/tb_sys_input_skew.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sys_input_skew_if.sv
// rtl/sys_input_skew_if.sv - buffer-side strobes/data in, skewed array-edge data out.
// Optional SYS_VALID_EN adds the per-lane valid_o bundle.
interface sys_input_skew_if #(
  parameter int LANES      = 8,
  parameter int DATA_WIDTH = 8
);
  logic                          ensys_i;
  logic                          bubble_i;
  logic [LANES*DATA_WIDTH-1:0]   data_i;
  logic [LANES*DATA_WIDTH-1:0]   data_o;
  logic                          busy_o;
`ifdef SYS_VALID_EN
  logic [LANES-1:0]              valid_o;

  modport master (
    output ensys_i, bubble_i, data_i,
    input  data_o, busy_o, valid_o
  );
  modport slave (
    input  ensys_i, bubble_i, data_i,
    output data_o, busy_o, valid_o
  );
`else
  modport master (
    output ensys_i, bubble_i, data_i,
    input  data_o, busy_o
  );
  modport slave (
    input  ensys_i, bubble_i, data_i,
    output data_o, busy_o
  );
`endif
endinterface

// File: rtl/sys_input_skew.sv
// rtl/sys_input_skew.sv - systolic input setup: strobe alignment, bubble zeroing, per-lane diagonal skew.
// Optional SYS_VALID_EN exposes per-lane tag bits as valid_o.
module sys_input_skew #(
  parameter int LANES      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LAT     = 1
) (
  input logic              clk_i,
  input logic              rst_ni,
  sys_input_skew_if.slave  bus
);

  localparam int DW = DATA_WIDTH;

  logic [RD_LAT-1:0] en_sr_q, en_sr_d;
  logic [RD_LAT-1:0] bub_sr_q, bub_sr_d;
  logic              en_a;
  logic              bub_a;
  logic              inj;
  logic [LANES*DW-1:0] slot;
  logic [DW-1:0]     lane_out [LANES];

  // Strobes ride a delay line matching the buffer read latency.
  always_comb begin
    en_sr_d     = en_sr_q;
    bub_sr_d    = bub_sr_q;
    en_sr_d[0]  = bus.ensys_i;
    bub_sr_d[0] = bus.bubble_i;
    for (int i = 1; i < RD_LAT; i++) begin
      en_sr_d[i]  = en_sr_q[i-1];
      bub_sr_d[i] = bub_sr_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_sr_q  <= '0;
      bub_sr_q <= '0;
    end else begin
      en_sr_q  <= en_sr_d;
      bub_sr_q <= bub_sr_d;
    end
  end

  assign en_a  = en_sr_q[RD_LAT-1];
  assign bub_a = bub_sr_q[RD_LAT-1];
  assign inj   = en_a & ~bub_a;

  // Zero the slot before any register so stale or unknown buffer data never enters the chain.
  assign slot = inj ? bus.data_i : '0;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [DW-1:0] pipe_q [k+1];
    logic [DW-1:0] pipe_d [k+1];

    always_comb begin
      pipe_d    = pipe_q;
      pipe_d[0] = slot[k*DW +: DW];
      for (int s = 1; s <= k; s++) begin
        pipe_d[s] = pipe_q[s-1];
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        pipe_q <= '{default: '0};
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign lane_out[k] = pipe_q[k];
  end

  always_comb begin
    bus.data_o = '0;
    for (int k = 0; k < LANES; k++) begin
      bus.data_o[k*DW +: DW] = lane_out[k];
    end
  end

`ifdef SYS_VALID_EN
  logic [LANES-1:0] lane_busy;
  logic [LANES-1:0] lane_valid;

  for (genvar k = 0; k < LANES; k++) begin : g_tag
    logic [k:0] tag_q, tag_d;

    always_comb begin
      tag_d    = tag_q;
      tag_d[0] = inj;
      for (int s = 1; s <= k; s++) begin
        tag_d[s] = tag_q[s-1];
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        tag_q <= '0;
      end else begin
        tag_q <= tag_d;
      end
    end

    assign lane_busy[k]  = |tag_q;
    assign lane_valid[k] = tag_q[k];
  end

  assign bus.valid_o = lane_valid;
  assign bus.busy_o  = |lane_busy;
`else
  // The longest lane's tag history covers every shorter lane, so one chain suffices for busy.
  logic [LANES-1:0] tag_q, tag_d;

  always_comb begin
    tag_d    = tag_q;
    tag_d[0] = inj;
    for (int s = 1; s < LANES; s++) begin
      tag_d[s] = tag_q[s-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign bus.busy_o = |tag_q;
`endif

endmodule

// File: tb/tb_sys_input_skew.sv
// tb/tb_sys_input_skew.sv - scoreboard bench driving RD_LAT=1 and RD_LAT=2 instances in parallel.
module tb_sys_input_skew;
  localparam int LANES = 8;
  localparam int DW    = 8;
  localparam int W     = LANES*DW;
  localparam int NCYC  = 110;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sys_input_skew_if #(.LANES(LANES), .DATA_WIDTH(DW)) bus1 ();
  sys_input_skew_if #(.LANES(LANES), .DATA_WIDTH(DW)) bus2 ();

  sys_input_skew #(.LANES(LANES), .DATA_WIDTH(DW), .RD_LAT(1)) dut1 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus1.slave)
  );

  sys_input_skew #(.LANES(LANES), .DATA_WIDTH(DW), .RD_LAT(2)) dut2 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus2.slave)
  );

  bit         s_en  [NCYC];
  bit         s_bub [NCYC];
  logic [W-1:0] s_dat [NCYC];

  // Scoreboard keyed by cycle*2 + instance (0: RD_LAT=1, 1: RD_LAT=2); absent key means all zero.
  logic [W-1:0]     exp_d [int];
  logic [LANES-1:0] exp_v [int];
  bit               exp_b [int];

  task automatic push_word(input int t, input logic [W-1:0] w);
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < LANES; k++) begin
        int key;
        logic [W-1:0]     d;
        logic [LANES-1:0] v;
        key = (t + 2 + u + k) * 2 + u;
        d = exp_d.exists(key) ? exp_d[key] : '0;
        v = exp_v.exists(key) ? exp_v[key] : '0;
        d[k*DW +: DW] = w[k*DW +: DW];
        v[k] = 1'b1;
        exp_d[key] = d;
        exp_v[key] = v;
        exp_b[key] = 1'b1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, want);
    end
  endtask

  task automatic check_dut(input int u, input logic [W-1:0] d, input logic b,
                           input logic [LANES-1:0] v);
    int key;
    key = cyc * 2 + u;
    chk(u == 0 ? "data_lat1" : "data_lat2", d,
        exp_d.exists(key) ? exp_d[key] : '0);
    chk(u == 0 ? "busy_lat1" : "busy_lat2", W'(b),
        W'(exp_b.exists(key) ? exp_b[key] : 1'b0));
`ifdef SYS_VALID_EN
    chk(u == 0 ? "valid_lat1" : "valid_lat2", W'(v),
        W'(exp_v.exists(key) ? exp_v[key] : '0));
`else
    if (v !== '0) begin
      checks++;
      errors++;
      $display("FAIL valid_tie cyc=%0d got=%h exp=0", cyc, v);
    end
`endif
  endtask

  // Monitor: samples both instances on the falling edge every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc >= NCYC) break;
`ifdef SYS_VALID_EN
      check_dut(0, bus1.data_o, bus1.busy_o, bus1.valid_o);
      check_dut(1, bus2.data_o, bus2.busy_o, bus2.valid_o);
`else
      check_dut(0, bus1.data_o, bus1.busy_o, '0);
      check_dut(1, bus2.data_o, bus2.busy_o, '0);
`endif
    end
  end

  initial begin
    int n;
    logic [W-1:0] w;

    for (int i = 0; i < NCYC; i++) begin
      s_en[i]  = 1'b0;
      s_bub[i] = 1'b0;
      s_dat[i] = 'x;
    end
    // Single word: lane k = k+1
    for (int k = 0; k < LANES; k++) w[k*DW +: DW] = 8'(k + 1);
    s_en[10] = 1'b1;
    s_dat[10] = w;
    // Streaming: four words, lane k of word j = 16*j+k
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < LANES; k++) w[k*DW +: DW] = 8'(16*j + k);
      s_en[30+j]  = 1'b1;
      s_dat[30+j] = w;
    end
    // Bubble padding: 8 strobes, last 5 are bubbles, data all FF
    for (int i = 50; i < 58; i++) begin
      s_en[i]  = 1'b1;
      s_bub[i] = (i >= 53);
      s_dat[i] = {W{1'b1}};
    end
    // Bubble without ensys, data left unknown
    s_bub[71] = 1'b1;
    s_bub[72] = 1'b1;
    // Stream interrupted by reset
    for (int j = 0; j < 5; j++) begin
      for (int k = 0; k < LANES; k++) w[k*DW +: DW] = 8'(8'hA0 + 16*j + k);
      s_en[84+j]  = 1'b1;
      s_dat[84+j] = w;
    end

    bus1.ensys_i = 1'b0; bus1.bubble_i = 1'b0; bus1.data_i = 'x;
    bus2.ensys_i = 1'b0; bus2.bubble_i = 1'b0; bus2.data_i = 'x;
    #2 rst_n = 1'b0;

    while (1) begin
      @(posedge clk);
      #1;
      n = cyc;
      if (n >= NCYC) break;
      if (n == 3 || n == 92) rst_n = 1'b1;
      bus1.ensys_i  = s_en[n];
      bus1.bubble_i = s_bub[n];
      bus2.ensys_i  = s_en[n];
      bus2.bubble_i = s_bub[n];
      bus1.data_i = (n >= 1 && s_en[n-1]) ? s_dat[n-1] : 'x;
      bus2.data_i = (n >= 2 && s_en[n-2]) ? s_dat[n-2] : 'x;
      if (s_en[n] && !s_bub[n] && rst_n) push_word(n, s_dat[n]);
      if (n == 88) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_data_lat1", bus1.data_o, '0);
        chk("rst_data_lat2", bus2.data_o, '0);
        chk("rst_busy_lat1", W'(bus1.busy_o), '0);
        chk("rst_busy_lat2", W'(bus2.busy_o), '0);
        exp_d.delete();
        exp_v.delete();
        exp_b.delete();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
